logic_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the single combinational two-input gate.
- Applies a runtime-selected bitwise operation (AND/OR/XOR/XNOR/NAND/NOR/NOT/PASS) to two WIDTH-bit operands.
- Carries the result through STAGES register stages with a valid/ready handshake on both sides.
- Also produces an all-ones flag per result and keeps a saturating count of flagged results. Sits between any producer/consumer pair as a registered logic datapath.

---
 rtl/logic_unit_pipe.sv | 114 +++++++++++
 tb/tb_logic_unit_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Purpose  : Runtime-selected bitwise op on two operands, carried through a
//            STAGES-deep valid/ready pipeline with an all-ones match counter.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic             out_all1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] match_cnt,
  input  logic             clr_cnt
);

  localparam logic [2:0] c_op_and  = 3'd0;
  localparam logic [2:0] c_op_or   = 3'd1;
  localparam logic [2:0] c_op_xor  = 3'd2;
  localparam logic [2:0] c_op_xnor = 3'd3;
  localparam logic [2:0] c_op_nand = 3'd4;
  localparam logic [2:0] c_op_nor  = 3'd5;
  localparam logic [2:0] c_op_not  = 3'd6;

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [WIDTH-1:0] w_res;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_all1;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [CNT_W-1:0]  r_cnt;

  always_comb begin
    w_res = '0;
    case (op)
      c_op_and:  w_res = in1 & in2;
      c_op_or:   w_res = in1 | in2;
      c_op_xor:  w_res = in1 ^ in2;
      c_op_xnor: w_res = ~(in1 ^ in2);
      c_op_nand: w_res = ~(in1 & in2);
      c_op_nor:  w_res = ~(in1 | in2);
      c_op_not:  w_res = ~in1;
      default:   w_res = in1;
    endcase
  end

  // A stage may load when it is empty or its content moves downstream this
  // cycle; evaluated from the output back so in_ready sees out_ready directly.
  always_comb begin
    w_load = '0;
    w_load[STAGES-1] = !r_valid[STAGES-1] || out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      w_load[i] = !r_valid[i] || w_load[i+1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_all1  <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= w_res;
          r_all1[0] <= &w_res;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_load[i]) begin
          r_valid[i] <= r_valid[i-1];
          if (r_valid[i-1]) begin
            r_data[i] <= r_data[i-1];
            r_all1[i] <= r_all1[i-1];
          end
        end
      end
    end
  end

  // Clear wins over a same-cycle increment; saturate instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
    end else if (out_valid && out_ready && out_all1 && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready  = w_load[0];
  assign out1      = r_data[STAGES-1];
  assign out_all1  = r_all1[STAGES-1];
  assign out_valid = r_valid[STAGES-1];
  assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_pipe
// Purpose  : Scoreboard bench for logic_unit_pipe (WIDTH=8, STAGES=2, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in1, in2;
  logic [2:0] op;
  logic       in_valid, in_ready;
  logic [7:0] out1;
  logic       out_all1, out_valid, out_ready;
  logic [1:0] match_cnt;
  logic       clr_cnt;

  logic_unit_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .op(op),
    .in_valid(in_valid), .in_ready(in_ready), .out1(out1),
    .out_all1(out_all1), .out_valid(out_valid), .out_ready(out_ready),
    .match_cnt(match_cnt), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       a;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t sq[$];
  int   oq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_acc = 0;
  bit   lat_on = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every output transfer pops one expected beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sq.size() == 0) begin
        check("unexpected_beat", {24'd0, out1}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sq.pop_front();
        check("out1", {24'd0, out1}, {24'd0, e.d});
        check("out_all1", {31'd0, out_all1}, {31'd0, e.a});
        if (e.lat) check("latency", cyc + 1 - e.acc, 2);
      end
      oq.push_back(cyc + 1);
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                      input logic [7:0] e, output int acc_edge);
    exp_t x;
    int n;
    in1 = a; in2 = b; op = o; in_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc_edge = -1;
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      x.d = e; x.a = (e == 8'hFF); x.acc = cyc + 1; x.lat = lat_on;
      acc_edge = cyc + 1;
      sq.push_back(x);
      n_acc++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", sq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ae, first, last, base;
    logic [7:0] t1 [8];
    logic [7:0] held;
    t1 = '{8'h05, 8'hAF, 8'hAA, 8'h55, 8'hFA, 8'h50, 8'h5A, 8'hA5};

    rst = 1'b1; in1 = '0; in2 = '0; op = '0; in_valid = 1'b0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out1", {24'd0, out1}, 0);
    check("rst_match_cnt", {30'd0, match_cnt}, 0);
    tick(2);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 1);

    // Test 1: all ops back to back
    for (int i = 0; i < 8; i++) send(8'hA5, 8'h0F, 3'(i), t1[i], ae);
    drain();
    check("t1_match_cnt", {30'd0, match_cnt}, 0);

    // Test 2: flagged results bump the counter
    send(8'h3C, 8'h3C, 3'd3, 8'hFF, ae);
    drain();
    check("t2_match_cnt_1", {30'd0, match_cnt}, 1);
    send(8'hFF, 8'hFF, 3'd0, 8'hFF, ae);
    drain();
    check("t2_match_cnt_2", {30'd0, match_cnt}, 2);

    // Test 3: stall with 4 beats
    lat_on = 1'b0;
    out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        send(8'hF0, 8'h3C, 3'd0, 8'h30, ae);
        send(8'h12, 8'h21, 3'd1, 8'h33, ae);
        send(8'hFF, 8'h0F, 3'd2, 8'hF0, ae);
        send(8'h00, 8'h00, 3'd5, 8'hFF, ae);
      end
      begin
        int n;
        n = 0;
        while (n_acc < base + 2 && n < 50) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        check("t3_in_ready_low", {31'd0, in_ready}, 0);
        check("t3_out_valid", {31'd0, out_valid}, 1);
        held = out1;
        check("t3_head", {24'd0, held}, 32'h30);
        repeat (3) @(negedge clk);
        check("t3_stable", {24'd0, out1}, {24'd0, held});
        check("t3_in_ready_still_low", {31'd0, in_ready}, 0);
        check("t3_accepted", n_acc - base, 2);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("t3_in_ready_back", {31'd0, in_ready}, 1);
    check("t3_match_cnt", {30'd0, match_cnt}, 3);

    // Test 4: 20 beats continuous
    lat_on = 1'b1;
    oq.delete();
    first = 0; last = 0;
    for (int i = 0; i < 20; i++) begin
      send(8'(i * 7), 8'h55, 3'd7, 8'(i * 7), ae);
      if (i == 0) first = ae;
      last = ae;
    end
    drain();
    check("t4_in_span", last - first, 19);
    check("t4_out_count", oq.size(), 20);
    if (oq.size() == 20) check("t4_out_span", oq[19] - oq[0], 19);

    // Test 5: saturation and clear priority
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    check("t5_cleared", {30'd0, match_cnt}, 0);
    for (int i = 0; i < 5; i++) send(8'h00, 8'h00, 3'd4, 8'hFF, ae);
    drain();
    check("t5_saturated", {30'd0, match_cnt}, 3);
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    check("t5_cleared_again", {30'd0, match_cnt}, 0);
    send(8'hF0, 8'h0F, 3'd1, 8'hFF, ae);
    tick(1);
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    check("t5_clr_priority", {30'd0, match_cnt}, 0);
    check("t5_clr_beat_done", sq.size(), 0);
    send(8'hF0, 8'h0F, 3'd1, 8'hFF, ae);
    drain();
    check("t5_count_after_clr", {30'd0, match_cnt}, 1);

    // Test 6: asynchronous reset mid-stream
    out_ready = 1'b0;
    send(8'hAA, 8'h55, 3'd1, 8'hFF, ae);
    send(8'h81, 8'h00, 3'd7, 8'h81, ae);
    check("t6_pre_valid", {31'd0, out_valid}, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", {31'd0, out_valid}, 0);
    check("t6_async_out1", {24'd0, out1}, 0);
    check("t6_async_all1", {31'd0, out_all1}, 0);
    check("t6_async_cnt", {30'd0, match_cnt}, 0);
    sq.delete();
    tick(2);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t6_in_ready", {31'd0, in_ready}, 1);
    oq.delete();
    send(8'h0F, 8'h3C, 3'd2, 8'h33, ae);
    drain();
    tick(3);
    check("t6_one_beat", oq.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
